// File: rtl/riscv_ctrl_pkg.sv
// Shared constants for the multicycle RV32I controller: opcodes, FSM state
// encoding and the datapath mux/ALU select encodings.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_ALUWB  = 4'd4,
    S_MEMADR = 4'd5,
    S_MEMRD  = 4'd6,
    S_MEMWB  = 4'd7,
    S_MEMWR  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10
  } state_t;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MDR    = 2'b01;
  localparam logic [1:0] RES_PC4    = 2'b10;

  // States that own the shared memory port and are therefore timed.
  function automatic logic is_mem_state(state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Shared instruction/data memory port: request side driven by the controller,
// completion strobe driven by the memory.
interface multicycle_controller_if;
  logic mem_req;
  logic mem_we;
  logic addr_sel;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output addr_sel, input mem_ready);
  modport slave  (input mem_req, input mem_we, input addr_sel, output mem_ready);
endinterface

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles while a memory state is active and flags a timeout
// when the count reaches WAIT_LIMIT without mem_ready (WAIT_LIMIT=0 disables).
module mem_wait_timer #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_mem_i,
  input  logic mem_ready_i,
  output logic timeout_o
);

  localparam int unsigned CW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIMIT   = CW'(WAIT_LIMIT);
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [CW-1:0] count_q, count_d;

  assign timeout_o = (WAIT_LIMIT != 0) && in_mem_i && !mem_ready_i && (count_q == LIMIT);

  // Every exit from a memory state goes through ready, timeout or a non-memory
  // state, so clearing on those gives a zero count on each new entry.
  always_comb begin
    count_d = count_q;
    if (!in_mem_i || mem_ready_i || timeout_o) begin
      count_d = '0;
    end else if (count_q != CNT_MAX) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values of its inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I sequencing FSM: walks each instruction through fetch,
// decode, execute, memory and writeback, decoding datapath controls from state.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [6:0]                    opcode,
  input  logic                          branch_cond,
  multicycle_controller_if.master       bus,
  output logic                          ir_write,
  output logic                          pc_write,
  output logic                          reg_write,
  output logic                          alu_src_a,
  output logic [1:0]                    alu_src_b,
  output logic [1:0]                    alu_op,
  output logic [1:0]                    result_src,
  output logic                          illegal_insn,
  output logic                          bus_error,
  output logic                          instr_retired,
  output logic [3:0]                    state_o
);

  state_t state_q, state_d;
  logic   mem_req, mem_we, addr_sel;
  logic   timeout;

  mem_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_mem_i    (is_mem_state(state_q)),
    .mem_ready_i (bus.mem_ready),
    .timeout_o   (timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    addr_sel      = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RS2;
    alu_op        = ALUOP_ADD;
    result_src    = RES_ALUOUT;
    illegal_insn  = 1'b0;
    bus_error     = 1'b0;
    instr_retired = 1'b0;

    unique case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (timeout) begin
          bus_error = 1'b1;
          state_d   = S_FETCH;
        end
      end

      S_DECODE: begin
        // ALU precomputes old_pc + imm so the branch target is ready next cycle.
        alu_src_b = SRCB_IMM;
        case (opcode)
          OP_R, OP_I:       state_d = S_EXEC;
          OP_LW, OP_SW:     state_d = S_MEMADR;
          OP_BR:            state_d = S_BRANCH;
          OP_JAL, OP_JALR:  state_d = S_JUMP;
          default: begin
            illegal_insn = 1'b1;
            state_d      = S_FETCH;
          end
        endcase
      end

      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
        alu_src_b = (opcode == OP_I) ? SRCB_IMM : SRCB_RS2;
        state_d   = S_ALUWB;
      end

      S_ALUWB: begin
        reg_write     = 1'b1;
        result_src    = RES_ALUOUT;
        instr_retired = 1'b1;
        state_d       = S_FETCH;
      end

      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end

      S_MEMRD: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        if (bus.mem_ready) begin
          state_d = S_MEMWB;
        end else if (timeout) begin
          bus_error = 1'b1;
          state_d   = S_FETCH;
        end
      end

      S_MEMWB: begin
        reg_write     = 1'b1;
        result_src    = RES_MDR;
        instr_retired = 1'b1;
        state_d       = S_FETCH;
      end

      S_MEMWR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        addr_sel = 1'b1;
        if (bus.mem_ready) begin
          instr_retired = 1'b1;
          state_d       = S_FETCH;
        end else if (timeout) begin
          bus_error = 1'b1;
          state_d   = S_FETCH;
        end
      end

      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_src_b     = SRCB_RS2;
        alu_op        = ALUOP_BRANCH;
        pc_write      = branch_cond;
        instr_retired = 1'b1;
        state_d       = S_FETCH;
      end

      S_JUMP: begin
        alu_src_a     = (opcode == OP_JALR);
        alu_src_b     = SRCB_IMM;
        reg_write     = 1'b1;
        result_src    = RES_PC4;
        pc_write      = 1'b1;
        instr_retired = 1'b1;
        state_d       = S_FETCH;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.mem_req  = mem_req;
  assign bus.mem_we   = mem_we;
  assign bus.addr_sel = addr_sel;
  assign state_o      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class cycle
// by cycle and compares state plus the full control word against hand values.
module tb_multicycle_controller;
  import riscv_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic       branch_cond = 1'b0;
  logic       ir_write, pc_write, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, result_src;
  logic       illegal_insn, bus_error, instr_retired;
  logic [3:0] dut_state;
  logic [15:0] obs_w;

  int n_cmp = 0;
  int n_err = 0;

  multicycle_controller_if bus ();

  multicycle_controller #(.WAIT_LIMIT(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .branch_cond   (branch_cond),
    .bus           (bus),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .result_src    (result_src),
    .illegal_insn  (illegal_insn),
    .bus_error     (bus_error),
    .instr_retired (instr_retired),
    .state_o       (dut_state)
  );

  always #5 clk = ~clk;

  // Control word: req we asel irw pcw rw srca srcb[2] op[2] res[2] ill berr ret
  assign obs_w = {bus.mem_req, bus.mem_we, bus.addr_sel, ir_write, pc_write, reg_write,
                  alu_src_a, alu_src_b, alu_op, result_src, illegal_insn, bus_error,
                  instr_retired};

  localparam logic [15:0] W_ZERO     = 16'b0_0_0_0_0_0_0_00_00_00_0_0_0;
  localparam logic [15:0] W_FETCH    = 16'b1_0_0_0_0_0_0_10_00_00_0_0_0;
  localparam logic [15:0] W_FETCH_OK = 16'b1_0_0_1_1_0_0_10_00_00_0_0_0;
  localparam logic [15:0] W_FETCH_TO = 16'b1_0_0_0_0_0_0_10_00_00_0_1_0;
  localparam logic [15:0] W_DECODE   = 16'b0_0_0_0_0_0_0_01_00_00_0_0_0;
  localparam logic [15:0] W_ILLEGAL  = 16'b0_0_0_0_0_0_0_01_00_00_1_0_0;
  localparam logic [15:0] W_EXEC_R   = 16'b0_0_0_0_0_0_1_00_10_00_0_0_0;
  localparam logic [15:0] W_EXEC_I   = 16'b0_0_0_0_0_0_1_01_10_00_0_0_0;
  localparam logic [15:0] W_ALUWB    = 16'b0_0_0_0_0_1_0_00_00_00_0_0_1;
  localparam logic [15:0] W_MEMADR   = 16'b0_0_0_0_0_0_1_01_00_00_0_0_0;
  localparam logic [15:0] W_MEMRD    = 16'b1_0_1_0_0_0_0_00_00_00_0_0_0;
  localparam logic [15:0] W_MEMWB    = 16'b0_0_0_0_0_1_0_00_00_01_0_0_1;
  localparam logic [15:0] W_MEMWR    = 16'b1_1_1_0_0_0_0_00_00_00_0_0_0;
  localparam logic [15:0] W_MEMWR_OK = 16'b1_1_1_0_0_0_0_00_00_00_0_0_1;
  localparam logic [15:0] W_MEMWR_TO = 16'b1_1_1_0_0_0_0_00_00_00_0_1_0;
  localparam logic [15:0] W_BR_T     = 16'b0_0_0_0_1_0_1_00_01_00_0_0_1;
  localparam logic [15:0] W_BR_N     = 16'b0_0_0_0_0_0_1_00_01_00_0_0_1;
  localparam logic [15:0] W_JAL      = 16'b0_0_0_0_1_1_0_01_00_10_0_0_1;
  localparam logic [15:0] W_JALR     = 16'b0_0_0_0_1_1_1_01_00_10_0_0_1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs are set just before calling; outputs settle for 1 ns, then compare.
  task automatic expect_st(input string tag, input state_t st, input logic [15:0] w);
    #1;
    check({tag, ".state"}, 32'(dut_state), 32'(st));
    check({tag, ".ctrl"}, 32'(obs_w), 32'(w));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_ok(input string tag, input logic [6:0] op);
    opcode        = op;
    bus.mem_ready = 1'b1;
    expect_st(tag, S_FETCH, W_FETCH_OK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.mem_ready = 1'b0;

    // Reset and start-up
    repeat (3) @(posedge clk);
    #1;
    expect_st("in_reset", S_IDLE, W_ZERO);
    rst_n = 1'b1;
    expect_st("post_rst_c1", S_IDLE, W_ZERO);
    step(); expect_st("post_rst_c2", S_FETCH, W_FETCH);

    // R-type, zero wait: reg_write in cycle 4, next fetch in cycle 5
    fetch_ok("r_c1", OP_R);
    step(); expect_st("r_c2", S_DECODE, W_DECODE);
    step(); expect_st("r_c3", S_EXEC, W_EXEC_R);
    step(); expect_st("r_c4", S_ALUWB, W_ALUWB);
    step(); fetch_ok("r_c5", OP_I);

    // I-type
    step(); expect_st("i_c2", S_DECODE, W_DECODE);
    step(); expect_st("i_c3", S_EXEC, W_EXEC_I);
    step(); expect_st("i_c4", S_ALUWB, W_ALUWB);
    step(); fetch_ok("lw_c1", OP_LW);

    // LW with 3 wait states in MEMRD
    step(); expect_st("lw_c2", S_DECODE, W_DECODE);
    step(); expect_st("lw_c3", S_MEMADR, W_MEMADR);
    step(); bus.mem_ready = 1'b0; expect_st("lw_wait1", S_MEMRD, W_MEMRD);
    step(); expect_st("lw_wait2", S_MEMRD, W_MEMRD);
    step(); expect_st("lw_wait3", S_MEMRD, W_MEMRD);
    step(); bus.mem_ready = 1'b1; expect_st("lw_ready", S_MEMRD, W_MEMRD);
    step(); expect_st("lw_wb", S_MEMWB, W_MEMWB);
    step(); branch_cond = 1'b1; fetch_ok("br_t_c1", OP_BR);

    // Branch taken / not taken
    step(); expect_st("br_t_c2", S_DECODE, W_DECODE);
    step(); expect_st("br_t_c3", S_BRANCH, W_BR_T);
    step(); branch_cond = 1'b0; fetch_ok("br_n_c1", OP_BR);
    step(); expect_st("br_n_c2", S_DECODE, W_DECODE);
    step(); expect_st("br_n_c3", S_BRANCH, W_BR_N);

    // JAL and JALR
    step(); fetch_ok("jal_c1", OP_JAL);
    step(); expect_st("jal_c2", S_DECODE, W_DECODE);
    step(); expect_st("jal_c3", S_JUMP, W_JAL);
    step(); fetch_ok("jalr_c1", OP_JALR);
    step(); expect_st("jalr_c2", S_DECODE, W_DECODE);
    step(); expect_st("jalr_c3", S_JUMP, W_JALR);

    // SW, zero wait
    step(); fetch_ok("sw_c1", OP_SW);
    step(); expect_st("sw_c2", S_DECODE, W_DECODE);
    step(); expect_st("sw_c3", S_MEMADR, W_MEMADR);
    step(); expect_st("sw_c4", S_MEMWR, W_MEMWR_OK);

    // SW timeout with WAIT_LIMIT=4: bus_error on the 5th wait cycle
    step(); fetch_ok("swto_c1", OP_SW);
    step(); expect_st("swto_c2", S_DECODE, W_DECODE);
    step(); expect_st("swto_c3", S_MEMADR, W_MEMADR);
    step(); bus.mem_ready = 1'b0; expect_st("swto_w1", S_MEMWR, W_MEMWR);
    step(); expect_st("swto_w2", S_MEMWR, W_MEMWR);
    step(); expect_st("swto_w3", S_MEMWR, W_MEMWR);
    step(); expect_st("swto_w4", S_MEMWR, W_MEMWR);
    step(); expect_st("swto_w5", S_MEMWR, W_MEMWR_TO);

    // Fetch timeout: stays in fetch, no IR/PC write, counter restarts
    step(); expect_st("fto_w1", S_FETCH, W_FETCH);
    step(); expect_st("fto_w2", S_FETCH, W_FETCH);
    step(); expect_st("fto_w3", S_FETCH, W_FETCH);
    step(); expect_st("fto_w4", S_FETCH, W_FETCH);
    step(); expect_st("fto_w5", S_FETCH, W_FETCH_TO);
    step(); expect_st("fto_refetch", S_FETCH, W_FETCH);

    // Illegal opcode: pulse in decode, back to fetch
    fetch_ok("ill_c1", 7'b1111111);
    step(); expect_st("ill_c2", S_DECODE, W_ILLEGAL);
    step(); fetch_ok("rst_c1", OP_LW);

    // Reset dropped mid-way through a read wait
    step(); expect_st("rst_c2", S_DECODE, W_DECODE);
    step(); expect_st("rst_c3", S_MEMADR, W_MEMADR);
    step(); bus.mem_ready = 1'b0; expect_st("rst_memrd", S_MEMRD, W_MEMRD);
    rst_n = 1'b0;
    expect_st("rst_async", S_IDLE, W_ZERO);
    step(); expect_st("rst_held", S_IDLE, W_ZERO);
    rst_n = 1'b1;
    step(); expect_st("rst_restart", S_FETCH, W_FETCH);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing FSM for the multicycle RV32I datapath: steps each instruction through fetch, decode, execute, memory and writeback, generating per-cycle enables and mux selects. Owns the single shared instruction/data memory port via a req/ready handshake, with a wait-timeout counter. Sits beside the datapath and replaces the single-cycle opcode decoder; ALU function decode stays in the existing ALU-control block, fed by `alu_op`.

## Interface
- `WAIT_LIMIT`, default 255: maximum cycles waiting for `mem_ready` before a bus error; 0 disables the timeout.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  7  opcode field from the instruction register (IR).
- `mem_ready`  in  1  memory has completed the current request this cycle.
- `branch_cond`  in  1  branch comparison true (combinational from the ALU compare path).
- `mem_req`  out  1  memory access request.
- `mem_we`  out  1  write strobe; only valid with `mem_req`.
- `addr_sel`  out  1  0 = PC drives the memory address, 1 = ALU-out register.
- `ir_write`  out  1  load IR and capture `old_pc`.
- `pc_write`  out  1  load PC from the ALU result.
- `reg_write`  out  1  register-file write enable.
- `alu_src_a`  out  1  0 = `old_pc`, 1 = rs1.
- `alu_src_b`  out  2  00 = rs2, 01 = immediate, 10 = constant 4.
- `alu_op`  out  2  00 = add (address/PC), 01 = branch compare, 10 = funct-decoded.
- `result_src`  out  2  00 = ALU-out register, 01 = memory data register, 10 = PC+4 link value.
- `illegal_insn`  out  1  one-cycle pulse when an unknown opcode is decoded.
- `bus_error`  out  1  one-cycle pulse on a memory wait timeout.
- `instr_retired`  out  1  one-cycle pulse in the final cycle of each completed instruction.
- `state_o`  out  4  current state encoding, for debug.

## Operation
- **Opcodes:**
  - R 0110011, I 0010011, LW 0000011, SW 0100011, BR 1100011, JAL 1101111, JALR 1100111.
  - Any other opcode is illegal.
- **Output style:** all outputs are decoded combinationally from state (plus `mem_ready`/`branch_cond` where noted). Any output not listed for a state is 0.
- **States and transitions:**
  - **S_IDLE:** reset state; unconditionally → S_FETCH.
  - **S_FETCH:**
    - Drives `mem_req=1`, `addr_sel=0`, `alu_src_a`=PC path, `alu_src_b=10`, `alu_op=00`.
    - When `mem_ready=1`: assert `ir_write=1` and `pc_write=1` (PC+4), then → S_DECODE.
  - **S_DECODE:** register read cycle; ALU computes `old_pc`+imm as the branch target.
    - R/I → S_EXEC; LW/SW → S_MEMADR; BR → S_BRANCH; JAL/JALR → S_JUMP.
    - Illegal → S_FETCH with `illegal_insn=1`; no retire.
  - **S_EXEC:** `alu_src_a=1`, `alu_op=10`; `alu_src_b=00` for R, `01` for I. → S_ALUWB.
  - **S_ALUWB:** `reg_write=1`, `result_src=00`, `instr_retired=1`. → S_FETCH.
  - **S_MEMADR:** `alu_src_a=1`, `alu_src_b=01`, `alu_op=00`. LW → S_MEMRD; SW → S_MEMWR.
  - **S_MEMRD:** `mem_req=1`, `addr_sel=1`. Wait for `mem_ready`, then → S_MEMWB.
  - **S_MEMWB:** `reg_write=1`, `result_src=01`, `instr_retired=1`. → S_FETCH.
  - **S_MEMWR:** `mem_req=1`, `mem_we=1`, `addr_sel=1`. When `mem_ready=1`: `instr_retired=1`, then → S_FETCH.
  - **S_BRANCH:** `alu_src_a=1`, `alu_src_b=00`, `alu_op=01`, `pc_write=branch_cond`, `instr_retired=1`. → S_FETCH.
  - **S_JUMP:** `reg_write=1`, `result_src=10`, `pc_write=1`, `instr_retired=1`. → S_FETCH.
    - JAL: target `old_pc`+imm (`alu_src_a=0`, `alu_src_b=01`).
    - JALR: target rs1+imm (`alu_src_a=1`, `alu_src_b=01`).
- **Handshake:**
  - `mem_req`, `mem_we` and `addr_sel` stay stable from the first request cycle until the cycle in which `mem_ready=1`.
  - `mem_ready` is ignored whenever `mem_req=0`.
  - Zero-wait memory, where `mem_ready` is high in the first request cycle, is legal.
- **Wait counter:**
  - Clears on entry to any memory state; increments in each memory-state cycle without `mem_ready`.
  - Width is clog2(WAIT_LIMIT+1); it saturates and never wraps.
  - When count == WAIT_LIMIT and `mem_ready=0`: `bus_error=1`, `mem_req` drops the next cycle, → S_FETCH.
  - Timeout writes nothing: no PC, IR or register write, and no retire.
  - A fetch timeout re-fetches the same PC, because PC was not advanced.
  - `mem_ready=1` in the limit cycle wins over timeout.

## Timing
- Reset: state = S_IDLE, wait counter = 0, all outputs 0. The first fetch request is asserted in the 2nd cycle after `rst_n` rises.
- Latency, fetch to next fetch, at zero wait states: R/I 4 cycles, LW 5, SW 4, BR 3, JAL/JALR 3, illegal 2.
- Each cycle that `mem_ready` is held low adds 1 cycle.
- `rst_n` asserted mid-instruction: immediate return to S_IDLE, outputs 0 asynchronously, and the in-flight request is abandoned.

## Structure
- **Package `riscv_ctrl_pkg`:**
  - Opcode constants.
  - `state_t` enum (4-bit).
  - Encodings for `alu_src_b`, `alu_op` and `result_src`.
- **Sub-module `mem_wait_timer`:** the wait counter plus timeout compare, instantiated once.
- **`multicycle_controller`:** next-state logic and the output decode.

## Test plan
- **Reset/start:** `rst_n` low 3 cycles, then high → `state_o`=S_IDLE, outputs 0, `mem_req=1` on the 2nd cycle after release.
- **R-type, zero wait:** `opcode`=0110011 with `mem_ready` tied high → `reg_write` in cycle 4 with `result_src=00`, one `instr_retired`, next fetch in cycle 5.
- **LW with 3 wait states:** `mem_ready` low 3 cycles in S_MEMRD → `mem_req`/`addr_sel=1` stable throughout; `reg_write` with `result_src=01` one cycle after `mem_ready`.
- **BR:** `opcode`=1100011 → `pc_write=1` in S_BRANCH only when `branch_cond=1`, `pc_write=0` when `branch_cond=0`; 3-cycle latency either way.
- **Timeout:** WAIT_LIMIT=4, SW with `mem_ready` held low → `bus_error` pulse on the 5th wait cycle; no `mem_we` acceptance, no retire, next state S_FETCH.
- **Illegal + mid-op reset:** `opcode`=1111111 → `illegal_insn` pulse in decode, back to fetch. `rst_n` dropped during S_MEMRD → outputs 0 immediately.
